// File: rtl/my_inc16_arb_pkg.sv
// ============================================================================
//  Module      : my_inc16_arb_pkg
//  Description : Shared types and helpers for the round-robin incrementer arbiter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package my_inc16_arb_pkg;

    localparam int NREQ_MAX = 8;

    typedef logic [2:0] req_id_t;

    // Successor of g in a ring of n requesters.
    function automatic req_id_t rr_next(input req_id_t g, input int unsigned n);
        if (32'(g) + 32'd1 >= n) begin
            return '0;
        end
        return g + 3'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/my_inc16.sv
// ============================================================================
//  Module      : my_inc16
//  Description : 16-bit incrementer with bit 15 as LSB; carry ripples 15 -> 0.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module my_inc16 (
    input  logic [15:0] a_i,
    output logic [15:0] y_o
);

    logic w_carry;

    always_comb begin
        y_o     = '0;
        w_carry = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            y_o[i]  = a_i[i] ^ w_carry;
            w_carry = w_carry & a_i[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/my_rr_pick.sv
// ============================================================================
//  Module      : my_rr_pick
//  Description : Combinational round-robin picker; scans from ptr_i with wrap.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module my_rr_pick
    import my_inc16_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    any_o
);

    localparam int IDW = $clog2(NREQ);

    int w_j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        w_j   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[w_j]) begin
                any_o      = 1'b1;
                gnt_o[w_j] = 1'b1;
                idx_o      = IDW'(w_j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/my_inc16_arb.sv
// ============================================================================
//  Module      : my_inc16_arb
//  Description : Round-robin share of one my_inc16 among NREQ requesters, with a
//                single valid/ready response register and a completion counter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module my_inc16_arb
    import my_inc16_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0][15:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [15:0]             rsp_data,
    output logic [15:0]             done_cnt
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic [15:0]     done_cnt_q, done_cnt_d;

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic            w_can_accept;
    logic            w_xfer;
    logic            w_drain;
    logic [15:0]     w_inc_data;
    logic [15:0]     w_inc_cnt;

    my_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (w_gnt),
        .idx_o (w_idx),
        .any_o (w_any)
    );

    my_inc16 u_inc_data (
        .a_i (req_data[w_idx]),
        .y_o (w_inc_data)
    );

    my_inc16 u_inc_cnt (
        .a_i (done_cnt_q),
        .y_o (w_inc_cnt)
    );

    // Draining and refilling in one cycle keeps one op per cycle sustained.
    assign w_can_accept = !rsp_valid_q || rsp_ready;
    assign w_xfer       = w_any && w_can_accept;
    assign w_drain      = rsp_valid_q && rsp_ready;
    assign req_ready    = w_gnt & {NREQ{w_can_accept}};

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        done_cnt_d  = done_cnt_q;
        if (w_drain) begin
            done_cnt_d  = w_inc_cnt;
            rsp_valid_d = 1'b0;
        end
        if (w_xfer) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = w_idx;
            rsp_data_d  = w_inc_data;
            ptr_d       = IDW'(rr_next(req_id_t'(w_idx), NREQ));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            done_cnt_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign done_cnt  = done_cnt_q;

endmodule

`default_nettype wire
